// File: rtl/lut_ram_mp.sv
// Purpose: distributed-RAM word store, one byte-masked write port, READ_PORTS async read ports, self-clearing after reset.
// Latency: reads take OUTPUT_REG cycles (0 = combinational, 1 = registered); writes land on the next rising edge.
// Backpressure: none; writes are dropped and rd_valid stays low until init_done. `define LUT_RAM_MP_BYPASS_EN to forward same-cycle writes to reads.
module lut_ram_mp #(
    parameter int DATA_WIDTH = 256,
    parameter int ADDR_WIDTH = 6,
    parameter int READ_PORTS = 2,
    parameter int OUTPUT_REG = 1
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             wr_en,
    input  logic [ADDR_WIDTH-1:0]            wr_addr,
    input  logic [DATA_WIDTH-1:0]            wr_data,
    input  logic [DATA_WIDTH/8-1:0]          wr_be,
    input  logic [READ_PORTS-1:0]            rd_en,
    input  logic [READ_PORTS*ADDR_WIDTH-1:0] rd_addr,
    output logic [READ_PORTS*DATA_WIDTH-1:0] rd_data,
    output logic [READ_PORTS-1:0]            rd_valid,
    output logic                             init_done
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int NB    = DATA_WIDTH / 8;

    typedef enum logic {CLEAR, READY} state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   clr_ptr;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic                    wr_accept;
    logic [DATA_WIDTH-1:0]   wr_merged;

    // Replace only the byte lanes whose enable bit is set.
    function automatic logic [DATA_WIDTH-1:0] merge_bytes(
        input logic [DATA_WIDTH-1:0] old_word,
        input logic [DATA_WIDTH-1:0] new_word,
        input logic [NB-1:0]         be
    );
        logic [DATA_WIDTH-1:0] res;
        res = old_word;
        for (int b = 0; b < NB; b++) begin
            if (be[b]) res[b*8 +: 8] = new_word[b*8 +: 8];
        end
        return res;
    endfunction

    // User writes are only honoured once the clear sweep has finished.
    assign wr_accept = wr_en && (state == READY);
    assign wr_merged = merge_bytes(mem[wr_addr], wr_data, wr_be);

    // Clear/ready sequencing: sweep every address once after reset, then open for traffic.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= CLEAR;
            clr_ptr   <= '0;
            init_done <= 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    clr_ptr <= clr_ptr + ADDR_WIDTH'(1);
                    if (&clr_ptr) begin
                        state     <= READY;
                        init_done <= 1'b1;
                    end
                end
                READY: begin
                    state <= READY;
                end
                default: begin
                    state <= CLEAR;
                end
            endcase
        end
    end

    // Storage update: zero fill during the sweep, byte-masked user writes afterwards; contents never reset directly.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (state == CLEAR) begin
                mem[clr_ptr] <= '0;
            end else if (wr_accept) begin
                mem[wr_addr] <= wr_merged;
            end
        end
    end

    for (genvar p = 0; p < READ_PORTS; p++) begin : g_rd
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] word;

        assign addr = rd_addr[p*ADDR_WIDTH +: ADDR_WIDTH];

`ifdef LUT_RAM_MP_BYPASS_EN
        // A same-cycle write to the read address is forwarded byte by byte.
        assign word = (wr_accept && (wr_addr == addr)) ? merge_bytes(mem[addr], wr_data, wr_be) : mem[addr];
`else
        // Reads see the array as it stood before this edge's write.
        assign word = mem[addr];
`endif

        if (OUTPUT_REG != 0) begin : g_reg
            logic [DATA_WIDTH-1:0] data_q;
            logic                  valid_q;

            // Registered read: capture on a valid request, otherwise hold the last word.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    data_q  <= '0;
                    valid_q <= 1'b0;
                end else begin
                    valid_q <= rd_en[p] && init_done;
                    if (rd_en[p] && init_done) data_q <= word;
                end
            end

            assign rd_data[p*DATA_WIDTH +: DATA_WIDTH] = data_q;
            assign rd_valid[p]                         = valid_q;
        end else begin : g_comb
            assign rd_data[p*DATA_WIDTH +: DATA_WIDTH] = word;
            assign rd_valid[p]                         = rd_en[p] && init_done;
        end
    end

endmodule

// File: tb/tb_lut_ram_mp.sv
// Purpose: self-checking bench for lut_ram_mp (default parameters, registered outputs).
// Latency: a reference model predicts every registered output one edge ahead; checks sample on the falling edge.
// Backpressure: none; directed scenarios followed by randomized traffic with occasional resets.
module tb_lut_ram_mp;

    localparam int DW    = 256;
    localparam int AW    = 6;
    localparam int RP    = 2;
    localparam int NB    = DW / 8;
    localparam int DEPTH = 1 << AW;

    logic             clk;
    logic             rst_n;
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [DW-1:0]    wr_data;
    logic [NB-1:0]    wr_be;
    logic [RP-1:0]    rd_en;
    logic [RP*AW-1:0] rd_addr;
    logic [RP*DW-1:0] rd_data;
    logic [RP-1:0]    rd_valid;
    logic             init_done;

    int vectors = 0;
    int errors  = 0;
    bit chk_en  = 1'b0;

    lut_ram_mp #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .READ_PORTS(RP),
        .OUTPUT_REG(1)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_be    (wr_be),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .init_done(init_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: memory array plus a count of clean cycles since reset release.
    logic [DW-1:0]    mmem [DEPTH];
    int               m_cnt = 0;
    logic [RP*DW-1:0] exp_data  = '0;
    logic [RP-1:0]    exp_valid = '0;
    logic             exp_init  = 1'b0;

    always @(posedge clk) begin
        logic          m_ready;
        logic [AW-1:0] a;
        logic [DW-1:0] w;
        if (!rst_n) begin
            m_cnt     = 0;
            exp_valid = '0;
            exp_data  = '0;
        end else begin
            m_ready = (m_cnt == DEPTH);
            for (int p = 0; p < RP; p++) begin
                a = rd_addr[p*AW +: AW];
                exp_valid[p] = rd_en[p] && m_ready;
                if (rd_en[p] && m_ready) begin
                    w = mmem[a];
`ifdef LUT_RAM_MP_BYPASS_EN
                    if (wr_en && wr_addr == a)
                        for (int b = 0; b < NB; b++)
                            if (wr_be[b]) w[b*8 +: 8] = wr_data[b*8 +: 8];
`endif
                    exp_data[p*DW +: DW] = w;
                end
            end
            if (m_ready && wr_en)
                for (int b = 0; b < NB; b++)
                    if (wr_be[b]) mmem[wr_addr][b*8 +: 8] = wr_data[b*8 +: 8];
            if (m_cnt < DEPTH) begin
                m_cnt++;
                if (m_cnt == DEPTH)
                    for (int i = 0; i < DEPTH; i++) mmem[i] = '0;
            end
        end
        exp_init = (m_cnt == DEPTH);
    end

    task automatic check(input string name, input logic [RP*DW-1:0] got, input logic [RP*DW-1:0] want);
        vectors++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    // Cycle-by-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("model_init_done", {{(RP*DW-1){1'b0}}, init_done}, {{(RP*DW-1){1'b0}}, exp_init});
            check("model_rd_valid",  {{(RP*DW-RP){1'b0}}, rd_valid}, {{(RP*DW-RP){1'b0}}, exp_valid});
            check("model_rd_data",   rd_data, exp_data);
        end
    end

    task automatic write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [NB-1:0] be);
        wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic read2(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        rd_en = 2'b11; rd_addr = {a1, a0};
        @(negedge clk);
        rd_en = 2'b00;
    endtask

    // Counts edges after release until init_done is seen; limit bounds the wait.
    task automatic wait_init(output int cycles, input int limit);
        cycles = -1;
        for (int k = 1; k <= limit; k++) begin
            @(negedge clk);
            if (init_done) begin
                cycles = k;
                break;
            end
        end
    endtask

    initial begin
        int               cyc;
        logic [RP*DW-1:0] want;
        logic [DW-1:0]    ones;
        logic [DW-1:0]    w;
        ones    = {DW{1'b1}};
        rst_n   = 1'b0;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        wr_be   = '0;
        rd_en   = '0;
        rd_addr = '0;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        check("reset_init_done", {{(RP*DW-1){1'b0}}, init_done}, '0);
        check("reset_rd_valid",  {{(RP*DW-RP){1'b0}}, rd_valid}, '0);
        check("reset_rd_data",   rd_data, '0);

        // Clear timing after release.
        rst_n = 1'b1;
        wait_init(cyc, 80);
        check("clear_cycles", RP*DW'(cyc), RP*DW'(64));

        // Every address reads zero after the sweep.
        for (int a = 0; a < DEPTH; a++) begin
            read2(AW'(a), AW'(DEPTH - 1 - a));
            if (rd_data != '0 || rd_valid != 2'b11) begin
                check("clear_zero", rd_data, '0);
            end
        end
        check("clear_zero_last", rd_data, '0);

        // Byte enables.
        write(6'd5, ones, {NB{1'b1}});
        write(6'd5, {NB{8'hAA}}, NB'(1));
        read2(6'd5, 6'd5);
        want = {{(DW-8){1'b1}}, 8'hAA, {(DW-8){1'b1}}, 8'hAA};
        check("byte_enable", rd_data, want);

        // Two ports, two addresses, one cycle.
        write(6'd3, DW'(8'h11), {NB{1'b1}});
        write(6'd9, DW'(8'h22), {NB{1'b1}});
        read2(6'd3, 6'd9);
        want = {DW'(8'h22), DW'(8'h11)};
        check("multi_port_data",  rd_data, want);
        check("multi_port_valid", {{(RP*DW-RP){1'b0}}, rd_valid}, {{(RP*DW-RP){1'b0}}, 2'b11});

        // Same-cycle read/write collision.
        write(6'd7, DW'(8'h01), {NB{1'b1}});
        wr_en = 1'b1; wr_addr = 6'd7; wr_data = DW'(8'h02); wr_be = {NB{1'b1}};
        rd_en = 2'b01; rd_addr = {6'd0, 6'd7};
        @(negedge clk);
        wr_en = 1'b0; rd_en = 2'b00;
        w = rd_data[DW-1:0];
`ifdef LUT_RAM_MP_BYPASS_EN
        check("collision", RP*DW'(w), RP*DW'(8'h02));
`else
        check("collision", RP*DW'(w), RP*DW'(8'h01));
`endif
        read2(6'd7, 6'd7);
        check("collision_after", rd_data, {DW'(8'h02), DW'(8'h02)});

        // Reset pulse in the middle of the clear sweep; writes during clear are dropped.
        write(6'd10, ones, {NB{1'b1}});
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            if (k == 5) begin
                wr_en = 1'b1; wr_addr = 6'd11; wr_data = ones; wr_be = {NB{1'b1}};
            end else begin
                wr_en = 1'b0;
            end
            @(negedge clk);
        end
        wr_en = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        wr_en = 1'b1; wr_addr = 6'd12; wr_data = ones; wr_be = {NB{1'b1}};
        wait_init(cyc, 80);
        wr_en = 1'b0;
        check("midclear_cycles", RP*DW'(cyc), RP*DW'(64));
        read2(6'd10, 6'd11);
        check("midclear_10_11", rd_data, '0);
        read2(6'd12, 6'd12);
        check("midclear_12", rd_data, '0);

        // Randomized traffic; low addresses favoured to provoke collisions.
        for (int i = 0; i < 3000; i++) begin
            rst_n   = ($urandom_range(0, 999) != 0);
            wr_en   = $urandom_range(0, 1);
            wr_addr = $urandom_range(0, 1) ? AW'($urandom_range(0, 3)) : AW'($urandom);
            for (int c = 0; c < DW / 32; c++) wr_data[c*32 +: 32] = $urandom;
            case ($urandom_range(0, 3))
                0:       wr_be = '0;
                1:       wr_be = {NB{1'b1}};
                default: wr_be = {$urandom};
            endcase
            rd_en = RP'($urandom);
            for (int p = 0; p < RP; p++)
                rd_addr[p*AW +: AW] = $urandom_range(0, 1) ? AW'($urandom_range(0, 3)) : AW'($urandom);
            @(negedge clk);
        end
        rst_n = 1'b1;
        wr_en = 1'b0;
        rd_en = '0;
        @(negedge clk);
        chk_en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/lut_ram_mp.md
LUT_RAM_MP -- requirements
Module: lut_ram_mp

Interface
REQ-001 Parameter DATA_WIDTH, default 256, SHALL set the word width in bits; it SHALL be a multiple of 8.
REQ-002 Parameter ADDR_WIDTH, default 6, SHALL set the address width; depth SHALL be 2**ADDR_WIDTH words.
REQ-003 Parameter READ_PORTS, default 2, SHALL set the number of independent read ports; legal range is 1..8.
REQ-004 Parameter OUTPUT_REG, default 1, SHALL select read latency: 0 means combinational, 1 means one registered cycle.
REQ-005 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-006 rst_n  input  1  SHALL be the reset: synchronous, active-low.
REQ-007 wr_en  input  1  SHALL be the write request.
REQ-008 wr_addr  input  ADDR_WIDTH  SHALL be the write address.
REQ-009 wr_data  input  DATA_WIDTH  SHALL be the write data.
REQ-010 wr_be  input  DATA_WIDTH/8  SHALL be the byte enables; bit i covers wr_data[8i+7:8i].
REQ-011 rd_en  input  READ_PORTS  SHALL be the per-port read request.
REQ-012 rd_addr  input  READ_PORTS*ADDR_WIDTH  SHALL be the packed read addresses; port p uses slice p.
REQ-013 rd_data  output  READ_PORTS*DATA_WIDTH  SHALL be the packed read data.
REQ-014 rd_valid  output  READ_PORTS  SHALL be the per-port read-data-valid flags.
REQ-015 init_done  output  1  SHALL be high when the clear sequence has completed and the RAM is accepting accesses.

Function
REQ-016 Storage SHALL be distributed (LUT) RAM with one write port and READ_PORTS asynchronous read ports.
REQ-017 The FSM SHALL have two states, CLEAR and READY; reset SHALL enter CLEAR with the clear pointer at 0.
REQ-018 In CLEAR:
- each cycle SHALL write all-zero to the clear pointer and increment it;
- after address 2**ADDR_WIDTH-1 is written, the FSM SHALL go to READY, so CLEAR lasts exactly 2**ADDR_WIDTH cycles.
REQ-019 In CLEAR, wr_en SHALL be ignored (the write is dropped) and rd_valid SHALL remain 0.
REQ-020 In READY, when wr_en=1, only the bytes with wr_be set SHALL be updated at wr_addr on the clock edge.
- wr_be all-zero SHALL leave memory unchanged.
REQ-021 init_done SHALL be registered and SHALL go high on the first cycle the FSM is in READY.
REQ-022 With OUTPUT_REG=0:
- rd_data for port p SHALL show mem[rd_addr_p] in the same cycle;
- rd_valid[p] SHALL equal rd_en[p] AND init_done.
REQ-023 With OUTPUT_REG=1:
- rd_data and rd_valid SHALL be registered, one cycle after the rd_en sample;
- rd_data SHALL hold its last value when rd_valid=0.
REQ-024 Multiple ports reading the same address in one cycle SHALL all return identical data.
REQ-025 Any rd_addr SHALL be legal; there is no out-of-range condition.
REQ-026 A read and a write to the same address in the same cycle SHALL follow REQ-031/REQ-032.

Reset
REQ-027 rst_n=0 sampled on an edge SHALL force:
- FSM to CLEAR, clear pointer to 0, init_done=0, rd_valid=0;
- rd_data to 0 when OUTPUT_REG=1.
REQ-028 Reset asserted mid-CLEAR or mid-READY SHALL restart the full clear sequence from address 0.
REQ-029 Memory contents SHALL NOT be reset directly; they SHALL become zero only through the CLEAR sequence.

Configuration
REQ-030 Macro LUT_RAM_MP_BYPASS_EN SHALL control write-to-read forwarding.
REQ-031 With LUT_RAM_MP_BYPASS_EN defined, a read whose address matches an accepted write in the same cycle SHALL return:
- new bytes where wr_be is set;
- old bytes elsewhere.
REQ-032 Without LUT_RAM_MP_BYPASS_EN, such a read SHALL return the pre-write (old) word.

Verification
REQ-033 The bench SHALL check clear timing: ADDR_WIDTH=6, release rst_n → init_done rises exactly 64 cycles later, and a read of every address returns 0.
REQ-034 The bench SHALL check byte enables: write 0xFF..FF to addr 5, then write 0xAA..AA with wr_be=0x0000_0001 → addr 5 reads 0xFF..FFAA.
REQ-035 The bench SHALL check multi-port reads: addr 3=0x11, addr 9=0x22; port0 reads 3 and port1 reads 9 in the same cycle (OUTPUT_REG=1) → next cycle rd_data = {0x22, 0x11} and rd_valid=2'b11.
REQ-036 The bench SHALL check collision: addr 7 holds 0x01; in one cycle write 0x02 (all bytes) and read 7 → 0x02 with the macro defined, 0x01 without it.
REQ-037 The bench SHALL check reset mid-clear: pulse rst_n low at clear cycle 30 → init_done stays 0 for 64 cycles after release, and the write attempted during CLEAR is absent afterwards.
